// File: rtl/instr_loader.sv
// Byte-serial program loader: assembles REG_WIDTH-bit words MSB-first, writes them to
// consecutive instruction-bank entries and holds the core in reset until the load completes.
module instr_loader #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_INSTR = 10,
  localparam int BYTES        = REG_WIDTH / 8,
  localparam int INSTR_SELECT = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1,
  localparam int CNT_WIDTH    = $clog2(NUM_INSTR + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [CNT_WIDTH-1:0]    i_num_words,
  input  logic                    i_valid,
  input  logic [7:0]              i_data,
  output logic                    o_ready,
  output logic                    o_write_enable,
  output logic [INSTR_SELECT-1:0] o_write_select,
  output logic [REG_WIDTH-1:0]    o_write_data,
  output logic                    o_core_rst,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  // Handshake: a byte moves on a rising edge where i_valid and o_ready are both 1.
  // o_ready depends only on state, so a producer may hold a byte across the WRITE cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [BCNT_W-1:0]     byte_cnt_q;
  logic [REG_WIDTH-1:0]  asm_q;

  logic                  len_bad;
  logic                  last_byte;
  logic                  last_word;
  logic [REG_WIDTH-1:0]  asm_shift;

  assign len_bad   = (i_num_words == '0) || (i_num_words > CNT_WIDTH'(NUM_INSTR));
  assign last_byte = (byte_cnt_q == BCNT_W'(BYTES - 1));
  assign last_word = (word_cnt_q == len_q - CNT_WIDTH'(1));
  // Shift form stays legal when REG_WIDTH is a single byte.
  assign asm_shift = (asm_q << 8) | REG_WIDTH'(i_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            if (len_bad) begin
              state_q <= ERROR;
            end else begin
              len_q      <= i_num_words;
              word_cnt_q <= '0;
              byte_cnt_q <= '0;
              state_q    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (i_valid) begin
            asm_q <= asm_shift;
            if (last_byte) begin
              byte_cnt_q <= '0;
              state_q    <= WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (last_word) begin
            state_q <= DONE;
          end else begin
            word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
            state_q    <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready        = (state_q == LOAD);
  assign o_write_enable = (state_q == WRITE);
  assign o_write_select = (state_q == WRITE) ? word_cnt_q[INSTR_SELECT-1:0] : '0;
  assign o_write_data   = (state_q == WRITE) ? asm_q : '0;
  assign o_core_rst     = (state_q != DONE);
  assign o_done         = (state_q == DONE);
  assign o_error        = (state_q == ERROR);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: randomized byte streams with gaps, expected bank writes held in a
// queue and checked every cycle, plus directed length-error, reset and restart cases.
module tb_instr_loader;

  localparam int W     = 32;
  localparam int N     = 10;
  localparam int BYTES = W / 8;
  localparam int SW    = 4;
  localparam int CW    = 4;
  localparam int BUDGET = 2000;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [CW-1:0] i_num_words;
  logic          i_valid;
  logic [7:0]    i_data;
  logic          o_ready;
  logic          o_write_enable;
  logic [SW-1:0] o_write_select;
  logic [W-1:0]  o_write_data;
  logic          o_core_rst;
  logic          o_done;
  logic          o_error;

  instr_loader #(.REG_WIDTH(W), .NUM_INSTR(N)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_words(i_num_words),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_write_enable(o_write_enable), .o_write_select(o_write_select),
    .o_write_data(o_write_data), .o_core_rst(o_core_rst), .o_done(o_done),
    .o_error(o_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [SW-1:0] last_sel;
  logic [W-1:0]  last_data;
  logic [W-1:0]  wbuf [16];
  logic [SW+W-1:0] exp_q [$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, bank writes must match the expected queue in order
  always @(posedge clk) begin
    logic [SW+W-1:0] e;
    #2;
    chk(o_core_rst === ~o_done, "core_rst_vs_done", {o_core_rst, o_done}, {~o_done, o_done});
    if (o_write_enable === 1'b1) begin
      chk(o_ready === 1'b0, "ready_in_write", o_ready, 0);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_write", {o_write_select, o_write_data}, 0);
      end else begin
        e = exp_q.pop_front();
        chk({o_write_select, o_write_data} === e, "write_word", {o_write_select, o_write_data}, e);
      end
      last_sel  = o_write_select;
      last_data = o_write_data;
      wr_cnt++;
    end else begin
      chk(o_write_select === '0 && o_write_data === '0, "bus_idle_zero",
          {o_write_select, o_write_data}, 0);
    end
    if (o_error === 1'b1)
      chk(o_done === 1'b0 && o_ready === 1'b0, "error_excl", {o_done, o_ready}, 0);
  end

  // driver tasks
  task automatic do_load(input int n, input int gap_pct, input int ign_at, input bit timed);
    int cyc = 0;
    int nb = 0;
    bit acc;
    logic [7:0] b;
    @(negedge clk);
    i_start = 1'b1;
    i_num_words = CW'(n);
    for (int w = 0; w < n; w++) exp_q.push_back({SW'(w), wbuf[w]});
    @(negedge clk);
    cyc = 1;
    i_start = 1'b0;
    chk(o_ready === 1'b1 && o_done === 1'b0 && o_core_rst === 1'b1, "load_entry",
        {o_ready, o_done, o_core_rst}, 3'b101);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < BYTES; k++) begin
        b = wbuf[w][8*(BYTES-1-k) +: 8];
        acc = 1'b0;
        while (!acc && cyc < BUDGET) begin
          if ($urandom_range(99) < gap_pct) begin
            i_valid = 1'b0;
            i_data = 8'($urandom);
          end else begin
            i_valid = 1'b1;
            i_data = b;
          end
          i_start = (nb == ign_at);
          i_num_words = i_start ? CW'($urandom_range(1, N)) : CW'(n);
          acc = i_valid && o_ready;
          @(negedge clk);
          cyc++;
        end
        nb++;
      end
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    while (o_done !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk(o_done === 1'b1, "done_reached", o_done, 1);
    if (timed) chk(cyc == 1 + n * (BYTES + 1), "load_latency", cyc, 1 + n * (BYTES + 1));
    chk(exp_q.size() == 0, "writes_completed", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic len_error(input int n);
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    i_start = 1'b1;
    i_num_words = CW'(n);
    @(negedge clk);
    i_start = 1'b0;
    chk(o_error === 1'b1 && o_core_rst === 1'b1 && o_ready === 1'b0 && o_done === 1'b0,
        "len_error", {o_error, o_core_rst, o_ready, o_done}, 4'b1100);
    repeat (3) @(negedge clk);
    chk(o_error === 1'b1, "error_hold", o_error, 1);
    chk(wr_cnt == w0, "error_no_write", wr_cnt - w0, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({o_ready, o_write_enable, o_write_select, o_write_data, o_core_rst, o_done, o_error} ===
        {1'b0, 1'b0, SW'(0), W'(0), 1'b1, 1'b0, 1'b0}, name,
        {o_ready, o_write_enable, o_write_select, o_core_rst, o_done, o_error}, 9'b000_0000_100);
  endtask

  initial begin
    int n;
    int w0;
    rst = 1'b1;
    i_start = 1'b0;
    i_num_words = '0;
    i_valid = 1'b0;
    i_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");

    // single word, valid held high
    wbuf[0] = 32'h12345678;
    do_load(1, 0, -1, 1'b1);
    chk(last_sel === 0 && last_data === 32'h12345678, "single_word_lit",
        {last_sel, last_data}, {SW'(0), 32'h12345678});

    // three words with gaps, stray start mid-load is ignored
    wbuf[0] = 32'hAABBCCDD; wbuf[1] = 32'h01020304; wbuf[2] = 32'hFFFFFFFF;
    w0 = wr_cnt;
    do_load(3, 40, 5, 1'b0);
    chk(wr_cnt - w0 == 3, "three_word_count", wr_cnt - w0, 3);
    chk(last_sel === 2 && last_data === 32'hFFFFFFFF, "three_word_lit",
        {last_sel, last_data}, {SW'(2), 32'hFFFFFFFF});

    // restart from DONE
    wbuf[0] = 32'hCAFEF00D;
    do_load(1, 20, -1, 1'b0);
    chk(last_sel === 0 && last_data === 32'hCAFEF00D, "restart_lit",
        {last_sel, last_data}, {SW'(0), 32'hCAFEF00D});

    // length errors
    len_error(0);
    len_error(11);
    len_error(15);

    // full bank from ERROR
    for (int i = 0; i < N; i++) wbuf[i] = $urandom;
    w0 = wr_cnt;
    do_load(N, 0, -1, 1'b1);
    chk(wr_cnt - w0 == N && last_sel === SW'(N - 1), "full_bank", {wr_cnt - w0, last_sel}, {N, N - 1});

    // reset mid-load
    @(negedge clk);
    i_start = 1'b1;
    i_num_words = CW'(2);
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b1;
    i_data = 8'hAA;
    @(negedge clk);
    i_data = 8'hBB;
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset_mid_load");
    wbuf[0] = 32'hDEADBEEF;
    do_load(1, 0, -1, 1'b1);
    chk(last_sel === 0 && last_data === 32'hDEADBEEF, "after_reset_lit",
        {last_sel, last_data}, {SW'(0), 32'hDEADBEEF});

    // randomized loads
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, N);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      w0 = wr_cnt;
      do_load(n, $urandom_range(0, 60), $urandom_range(0, 40), 1'b0);
      chk(wr_cnt - w0 == n, "rand_count", wr_cnt - w0, n);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction bank that the core only ever reads.
- Accepts a byte-serial program stream over a valid/ready handshake and assembles REG_WIDTH-bit instruction words.
- Writes each word into consecutive instruction-bank entries through the bank's write port (enable/select/data).
- Holds the core in reset until the whole program is written, then releases it.

Parameters:
REG_WIDTH, 32, instruction word width; must be a multiple of 8 (BYTES = REG_WIDTH/8)
NUM_INSTR, 10, number of instruction-bank entries (INSTR_SELECT = $clog2(NUM_INSTR), CNT_WIDTH = $clog2(NUM_INSTR+1))

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
i_start  input  1  one-cycle load request; sampled only in IDLE, DONE or ERROR
i_num_words  input  CNT_WIDTH  program length in words; latched when i_start is accepted
i_valid  input  1  stream byte valid
i_data  input  8  stream byte; the first byte of each word is the MSB
o_ready  output  1  loader accepts i_data this cycle
o_write_enable  output  1  instruction-bank write enable
o_write_select  output  INSTR_SELECT  instruction-bank write index
o_write_data  output  REG_WIDTH  instruction-bank write data
o_core_rst  output  1  reset to the core (PC, registers, memory)
o_done  output  1  program loaded; core running
o_error  output  1  rejected length request

Behaviour:
- Reset (rst=1 at a clock edge) forces state IDLE and clears word_cnt, byte_cnt and the assembly register.
- Outputs after reset: o_ready=0, o_write_enable=0, o_write_select=0, o_write_data=0, o_core_rst=1, o_done=0, o_error=0.
- Reset mid-load aborts the load immediately. Entries already written stay in the bank; the loader never clears them.
- All outputs are decoded from registered state, counters and the assembly register. There is no combinational path from i_* to o_*.
- States: IDLE, LOAD, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR, on i_start=1:
  - If i_num_words==0 or i_num_words>NUM_INSTR: go to ERROR.
  - Otherwise: latch the length, clear word_cnt and byte_cnt, go to LOAD.
  - Without i_start, stay in the current state.
- LOAD:
  - o_ready=1. A byte is accepted when i_valid & o_ready.
  - On accept: asm <= {asm[REG_WIDTH-9:0], i_data} and byte_cnt increments.
  - On the accept where byte_cnt==BYTES-1: byte_cnt returns to 0 and the state goes to WRITE.
  - i_valid=0 leaves the state unchanged.
- WRITE (exactly one cycle):
  - o_ready=0, o_write_enable=1, o_write_select=word_cnt[INSTR_SELECT-1:0], o_write_data=asm.
  - The bank captures the word at the edge that ends this cycle.
  - Next state: if word_cnt==latched length-1, go to DONE; else increment word_cnt and go to LOAD.
- DONE: o_done=1, o_core_rst=0. The core leaves reset on the first DONE cycle.
- ERROR: o_error=1. No bank writes occur.
- o_core_rst=1 in every state except DONE.
- Re-load: i_start in DONE reasserts o_core_rst from the next cycle; o_done drops at the same time.
- i_start in LOAD or WRITE is ignored.
- Output defaults: o_write_enable=0 outside WRITE. o_write_select and o_write_data are 0 outside WRITE.
- Byte held while o_ready=0 (the WRITE cycle): it is not consumed and must still be presented when LOAD resumes.
- Throughput: minimum BYTES+1 cycles per word. Minimum total load time from i_start is 1 + N*(BYTES+1) cycles to the first DONE cycle.
- Width rules: word_cnt and the latched length are CNT_WIDTH bits; the index never exceeds NUM_INSTR-1.

Test Plan:
- Single word: rst; i_start, i_num_words=1; bytes 12,34,56,78 with i_valid held high -> one cycle with o_write_enable=1, select=0, data=32'h12345678. o_done=1 and o_core_rst=0 on the next cycle. o_ready=0 during WRITE.
- Three words with i_valid gaps: words AABBCCDD, 01020304, FFFFFFFF -> writes at select 0,1,2 in order, each with the exact word. The byte presented during the WRITE cycle is consumed only after o_ready returns to 1.
- Length errors:
  - i_num_words=0 -> ERROR next cycle, o_error=1, o_core_rst=1, no write.
  - i_num_words=11 -> same as 0.
  - i_num_words=10 -> ten writes, last select=9, then DONE.
- Reset mid-load: i_num_words=2; 2 bytes; rst for 1 cycle -> all outputs at reset values. New load of 1 word DEADBEEF -> data=32'hDEADBEEF with no stale bytes.
- Restart from DONE: i_start during LOAD is ignored (word count unaffected). i_start in DONE -> o_core_rst=1, o_done=0 next cycle, and a fresh load of 1 word writes select=0.
